// File: rtl/packet_buffer_read_arbiter_pkg.sv
// Shared constants and types for the packet buffer read arbiter.
package packet_buffer_read_arbiter_pkg;

  localparam int BYTE_LEN                   = 8;
  localparam int PACKET_BUFFER_SIZE         = 256;
  localparam int PACKET_BUFFER_READ_LATENCY = 2;
  localparam int TAG_W                      = 1;

  // Requester identity: port 0 is the TX serializer, port 1 the crypto/CRC engine.
  typedef enum logic {
    PORT_0 = 1'b0,
    PORT_1 = 1'b1
  } port_id_e;

  // A valid/id pair, used both for the grant decision and the lock owner.
  typedef struct packed {
    logic     valid;
    port_id_e id;
  } sel_t;

  // Grant decision in priority order: live lock owner, lone requester,
  // then round-robin away from the last served port.
  function automatic sel_t arb_decide(input logic req0, input logic req1,
                                      input sel_t owner, input port_id_e last);
    sel_t g;
    g.valid = 1'b0;
    g.id    = PORT_0;
    if (owner.valid && ((owner.id == PORT_0) ? req0 : req1)) begin
      g.valid = 1'b1;
      g.id    = owner.id;
    end else if (req0 && !req1) begin
      g.valid = 1'b1;
      g.id    = PORT_0;
    end else if (req1 && !req0) begin
      g.valid = 1'b1;
      g.id    = PORT_1;
    end else if (req0 && req1) begin
      g.valid = 1'b1;
      g.id    = (last == PORT_0) ? PORT_1 : PORT_0;
    end
    return g;
  endfunction

endpackage

// File: rtl/packet_buffer_read_arbiter_read_tag_pipe.sv
// Fixed-length shift register of {valid, tag}; tracks which requester owns
// each read in flight so the returning byte can be steered back to it.
module read_tag_pipe #(
  parameter int DELAY_LEN = 2,
  parameter int TAG_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  output logic [TAG_WIDTH-1:0] out_tag
);

  logic [DELAY_LEN-1:0] valid_q;
  logic [TAG_WIDTH-1:0] tag_q [DELAY_LEN];

  // Shift one stage per cycle; reset drops every read in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DELAY_LEN; i++) tag_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      tag_q[0]   <= in_tag;
      for (int i = 1; i < DELAY_LEN; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DELAY_LEN-1];
  assign out_tag   = tag_q[DELAY_LEN-1];

endmodule

// File: rtl/packet_buffer_read_arbiter.sv
// Shares the packet buffer RAM read port between two requesters with
// per-cycle round-robin, an optional burst lock, and tagged return routing.
//
// Handshake: a requester raises reqN with a stable addrN and holds both until
// grantN is seen high in the same cycle; that cycle the read is issued. The
// byte comes back READ_LATENCY cycles later as a one-cycle readyN pulse with
// dataN valid. There is no backpressure on the return path.
module packet_buffer_read_arbiter
  import packet_buffer_read_arbiter_pkg::*;
#(
  parameter int RAM_SIZE     = PACKET_BUFFER_SIZE,
  parameter int READ_LATENCY = PACKET_BUFFER_READ_LATENCY,
  localparam int ADDR_W      = $clog2(RAM_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                req1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic                lock0,
  input  logic                lock1,
  output logic                grant0,
  output logic                grant1,
  output logic                ready0,
  output logic                ready1,
  output logic [BYTE_LEN-1:0] data0,
  output logic [BYTE_LEN-1:0] data1,
  output logic                ram_read_req,
  output logic [ADDR_W-1:0]   ram_read_addr,
  input  logic                ram_read_ready,
  input  logic [BYTE_LEN-1:0] ram_read_out
);

  port_id_e          last_q;
  sel_t              owner_q;
  sel_t              grant;
  logic              tail_valid;
  logic [TAG_W-1:0]  tail_tag;
  logic [TAG_W-1:0]  issue_tag;

  // Grant decision; nothing is issued while reset is held.
  always_comb begin
    grant.valid = 1'b0;
    grant.id    = PORT_0;
    if (!reset) grant = arb_decide(req0, req1, owner_q, last_q);
  end

  assign grant0       = grant.valid && (grant.id == PORT_0);
  assign grant1       = grant.valid && (grant.id == PORT_1);
  assign ram_read_req = grant.valid;

  // Drive the granted address to the RAM, zero while idle.
  always_comb begin
    ram_read_addr = '0;
    if (grant.valid) ram_read_addr = (grant.id == PORT_0) ? addr0 : addr1;
  end

  // Round-robin pointer and lock owner. A cycle with no grant means the owner
  // (if any) dropped req, so the lock is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q        <= PORT_1;
      owner_q.valid <= 1'b0;
      owner_q.id    <= PORT_0;
    end else if (grant.valid) begin
      last_q        <= grant.id;
      owner_q.valid <= (grant.id == PORT_0) ? lock0 : lock1;
      owner_q.id    <= grant.id;
    end else begin
      owner_q.valid <= 1'b0;
    end
  end

  assign issue_tag = grant.id;

  read_tag_pipe #(
    .DELAY_LEN (READ_LATENCY),
    .TAG_WIDTH (TAG_W)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (ram_read_req),
    .in_tag    (issue_tag),
    .out_valid (tail_valid),
    .out_tag   (tail_tag)
  );

  // A RAM return with no matching tag is dropped silently.
  assign ready0 = ram_read_ready && tail_valid && (tail_tag == TAG_W'(PORT_0));
  assign ready1 = ram_read_ready && tail_valid && (tail_tag == TAG_W'(PORT_1));
  assign data0  = ram_read_out;
  assign data1  = ram_read_out;

endmodule

// File: tb/tb_packet_buffer_read_arbiter.sv
// Bench for packet_buffer_read_arbiter: directed vector table plus random
// traffic, checked against a queue-based reference model.
module tb_packet_buffer_read_arbiter;
  import packet_buffer_read_arbiter_pkg::*;

  localparam int LAT = 2;
  localparam int RSZ = 256;
  localparam int AW  = 8;
  localparam int EW  = 32 + 1 + 8;

  logic          clk;
  logic          reset;
  logic          req0, req1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic          grant0, grant1, ready0, ready1;
  logic [7:0]    data0, data1;
  logic          ram_read_req;
  logic [AW-1:0] ram_read_addr;
  logic          ram_read_ready;
  logic [7:0]    ram_read_out;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  packet_buffer_read_arbiter #(
    .RAM_SIZE     (RSZ),
    .READ_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .req1           (req1),
    .addr0          (addr0),
    .addr1          (addr1),
    .lock0          (lock0),
    .lock1          (lock1),
    .grant0         (grant0),
    .grant1         (grant1),
    .ready0         (ready0),
    .ready1         (ready1),
    .data0          (data0),
    .data1          (data1),
    .ram_read_req   (ram_read_req),
    .ram_read_addr  (ram_read_addr),
    .ram_read_ready (ram_read_ready),
    .ram_read_out   (ram_read_out)
  );

  int tests;
  int fails;
  int cyc;

  // RAM driver stand-in: mem[a] = a, returned LAT cycles after the request.
  logic       ram_v [LAT];
  logic [7:0] ram_d [LAT];

  // Reference model state: {due cycle, requester id, byte}.
  logic [EW-1:0] exp_q [$];
  int m_last;
  int m_owner;

  typedef struct {
    logic [4:0] ctl;   // {rst, req0, req1, lock0, lock1}
    logic [7:0] a0;
    logic [7:0] a1;
    logic       frc;
    logic [3:0] ex;    // {grant0, grant1, ready0, ready1}
    logic [7:0] ed;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mkv(input logic [4:0] ctl, input logic [7:0] a0,
                               input logic [7:0] a1, input logic frc,
                               input logic [3:0] ex, input logic [7:0] ed);
    vec_t v;
    v.ctl = ctl; v.a0 = a0; v.a1 = a1; v.frc = frc; v.ex = ex; v.ed = ed;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, check at negedge, advance the models.
  task automatic run_cycle(input logic r, input logic r0, input logic r1,
                           input logic l0, input logic l1,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input logic frc, input logic use_t,
                           input logic [3:0] tex, input logic [7:0] ted);
    int            g;
    logic          mr0, mr1, rr;
    logic [7:0]    md, ra, maddr;
    logic [EW-1:0] e;
    reset = r; req0 = r0; req1 = r1; lock0 = l0; lock1 = l1;
    addr0 = a0; addr1 = a1;
    ram_read_ready = ram_v[LAT-1] | frc;
    ram_read_out   = ram_v[LAT-1] ? ram_d[LAT-1] : 8'($urandom);
    @(negedge clk);

    g = -1;
    if (!r) begin
      if (m_owner == 0 && r0)      g = 0;
      else if (m_owner == 1 && r1) g = 1;
      else if (r0 && !r1)          g = 0;
      else if (r1 && !r0)          g = 1;
      else if (r0 && r1)           g = 1 - m_last;
    end
    maddr = (g == 0) ? a0 : (g == 1) ? a1 : 8'h00;

    mr0 = 1'b0; mr1 = 1'b0; md = 8'h00;
    if (r) exp_q.delete();
    else if (exp_q.size() > 0 && int'(exp_q[0][EW-1:9]) == cyc) begin
      e = exp_q.pop_front();
      if (ram_read_ready) begin
        if (e[8]) mr1 = 1'b1; else mr0 = 1'b1;
        md = e[7:0];
      end
    end

    check("grant0", 32'(grant0), 32'(g == 0));
    check("grant1", 32'(grant1), 32'(g == 1));
    check("ram_read_req", 32'(ram_read_req), 32'(g >= 0));
    check("ram_read_addr", 32'(ram_read_addr), 32'(maddr));
    check("ready0", 32'(ready0), 32'(mr0));
    check("ready1", 32'(ready1), 32'(mr1));
    if (mr0) check("data0", 32'(data0), 32'(md));
    if (mr1) check("data1", 32'(data1), 32'(md));

    if (use_t) begin
      check("tbl_grant0", 32'(grant0), 32'(tex[3]));
      check("tbl_grant1", 32'(grant1), 32'(tex[2]));
      check("tbl_ready0", 32'(ready0), 32'(tex[1]));
      check("tbl_ready1", 32'(ready1), 32'(tex[0]));
      if (tex[1]) check("tbl_data0", 32'(data0), 32'(ted));
      if (tex[0]) check("tbl_data1", 32'(data1), 32'(ted));
    end

    rr = ram_read_req;
    ra = ram_read_addr;

    if (r) begin
      m_last = 1; m_owner = -1;
    end else if (g >= 0) begin
      m_last  = g;
      m_owner = (((g == 0) ? l0 : l1) == 1'b1) ? g : -1;
      exp_q.push_back({32'(cyc + LAT), g[0], maddr});
    end else begin
      m_owner = -1;
    end

    @(posedge clk);
    for (int i = LAT - 1; i > 0; i--) begin
      ram_v[i] = ram_v[i-1];
      ram_d[i] = ram_d[i-1];
    end
    ram_v[0] = rr;
    ram_d[0] = ra;
    #1;
    cyc++;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    m_last = 1; m_owner = -1;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = '0; addr1 = '0; ram_read_ready = 1'b0; ram_read_out = '0;
    for (int i = 0; i < LAT; i++) begin ram_v[i] = 1'b0; ram_d[i] = '0; end

    // ctl = {rst,req0,req1,lock0,lock1}; ex = {g0,g1,r0,r1}
    // single requester
    tbl.push_back(mkv(5'b01000, 8'h10, 8'h00, 1'b0, 4'b1000, 8'h00));
    tbl.push_back(mkv(5'b01000, 8'h11, 8'h00, 1'b0, 4'b1000, 8'h00));
    tbl.push_back(mkv(5'b01000, 8'h12, 8'h00, 1'b0, 4'b1010, 8'h10));
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b0, 4'b0010, 8'h11));
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b0, 4'b0010, 8'h12));
    // contention from reset
    tbl.push_back(mkv(5'b10000, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h00));
    tbl.push_back(mkv(5'b01100, 8'h20, 8'h30, 1'b0, 4'b1000, 8'h00));
    tbl.push_back(mkv(5'b01100, 8'h20, 8'h30, 1'b0, 4'b0100, 8'h00));
    tbl.push_back(mkv(5'b01100, 8'h20, 8'h30, 1'b0, 4'b1010, 8'h20));
    tbl.push_back(mkv(5'b01100, 8'h20, 8'h30, 1'b0, 4'b0101, 8'h30));
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b0, 4'b0010, 8'h20));
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b0, 4'b0001, 8'h30));
    // burst lock by port 1 against a waiting port 0
    tbl.push_back(mkv(5'b01000, 8'h02, 8'h00, 1'b0, 4'b1000, 8'h00));
    tbl.push_back(mkv(5'b01101, 8'h03, 8'h44, 1'b0, 4'b0100, 8'h00));
    tbl.push_back(mkv(5'b01101, 8'h03, 8'h44, 1'b0, 4'b0110, 8'h02));
    tbl.push_back(mkv(5'b01101, 8'h03, 8'h44, 1'b0, 4'b0101, 8'h44));
    tbl.push_back(mkv(5'b01101, 8'h03, 8'h44, 1'b0, 4'b0101, 8'h44));
    tbl.push_back(mkv(5'b01000, 8'h03, 8'h00, 1'b0, 4'b1001, 8'h44));
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b0, 4'b0001, 8'h44));
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b0, 4'b0010, 8'h03));
    // reset mid-flight
    tbl.push_back(mkv(5'b01000, 8'h40, 8'h00, 1'b0, 4'b1000, 8'h00));
    tbl.push_back(mkv(5'b11000, 8'h41, 8'h00, 1'b0, 4'b0000, 8'h00));
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h00));
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h00));
    // back-to-back plus idle
    tbl.push_back(mkv(5'b00100, 8'h00, 8'h55, 1'b0, 4'b0100, 8'h00));
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h00));
    tbl.push_back(mkv(5'b01000, 8'h66, 8'h00, 1'b0, 4'b1001, 8'h55));
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b0, 4'b0000, 8'h00));
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b0, 4'b0010, 8'h66));
    // spurious RAM ready
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b1, 4'b0000, 8'h00));
    tbl.push_back(mkv(5'b00000, 8'h00, 8'h00, 1'b1, 4'b0000, 8'h00));

    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 4'b0000, 8'h00);
    run_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 8'h09, 1'b0, 1'b1, 4'b0000, 8'h00);

    foreach (tbl[i])
      run_cycle(tbl[i].ctl[4], tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].ctl[1],
                tbl[i].ctl[0], tbl[i].a0, tbl[i].a1, tbl[i].frc, 1'b1,
                tbl[i].ex, tbl[i].ed);

    // random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      run_cycle(($urandom_range(0, 79) == 0),
                ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                ($urandom_range(0, 15) == 0), 1'b0, 4'b0000, 8'h00);
    end

    // drain
    for (int n = 0; n < LAT + 2; n++)
      run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'b0000, 8'h00);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/packet_buffer_read_arbiter.md
Name: packet_buffer_read_arbiter

Overview:
- Shares the single read port of packet_buffer_ram_driver between two requesters: the Ethernet TX serializer (port 0) and the encryption/CRC engine (port 1).
- Arbitrates round-robin per cycle and supports a burst lock.
- Tags each issued read and routes the returned byte back to the requester that issued it, READ_LATENCY cycles later.
- Sits between the requesters and the RAM driver; the write side of the RAM is untouched.

Parameters:
- RAM_SIZE, PACKET_BUFFER_SIZE: RAM depth in bytes; address width is clog2(RAM_SIZE).
- READ_LATENCY, PACKET_BUFFER_READ_LATENCY: cycles from ram_read_req to ram_read_ready; must be at least 1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  read request from requester 0 / 1; held until granted.
- addr0, addr1  in  clog2(RAM_SIZE) each  read address for requester 0 / 1.
- lock0, lock1  in  1 each  burst lock; keeps the grant with this requester while it is asserted.
- grant0, grant1  out  1 each  request accepted this cycle (combinational).
- ready0, ready1  out  1 each  data for requester 0 / 1 is valid this cycle.
- data0, data1  out  BYTE_LEN each  returned byte; valid only while the matching ready is high.
- ram_read_req  out  1  to the RAM driver read_req.
- ram_read_addr  out  clog2(RAM_SIZE)  to the RAM driver read_addr.
- ram_read_ready  in  1  from the RAM driver read_ready.
- ram_read_out  in  BYTE_LEN  from the RAM driver read_out.

Behaviour:
- Reset values: the last-served pointer `last` resets to 1, so port 0 has priority on the first contested cycle. The lock owner is cleared. All tag-pipeline entries are invalid. grant*, ready*, ram_read_req are 0; ram_read_addr is 0 while idle.
- Throughput: one read issued per cycle at most. No internal queue; a requester simply holds req until its grant.
- Grant decision (combinational, in priority order):
  - If a lock owner is recorded and that owner's req is high, the owner is granted.
  - Otherwise, if only one req is high, that requester is granted.
  - Otherwise, if both are high, the requester other than `last` is granted.
  - Otherwise, nothing is granted.
- On a grant: ram_read_req = 1 and ram_read_addr = the granted requester's addr, in the same cycle.
- Sequential updates on a grant:
  - `last` is set to the granted id.
  - The lock owner is set to the granted id if its lock is high; otherwise it is cleared.
- A lock owner that drops req releases the lock immediately; the other requester can be granted in that same cycle.
- Tag pipeline:
  - READ_LATENCY stages of {valid, id}.
  - Stage 0 loads {ram_read_req, granted id}; the contents shift every cycle.
- Return routing:
  - readyN = ram_read_ready AND tail.valid AND (tail.id == N).
  - dataN = ram_read_out, muxed unconditionally; data is meaningful only when readyN is high.
- ram_read_ready high while the tail entry is invalid: a protocol error. Both ready outputs stay 0 and the byte is dropped.
- Reset mid-burst: all tags are cleared, so bytes returning afterwards produce no ready pulse. Requesters must re-issue.
- Simultaneous events:
  - The grant and the tail return in the same cycle are independent; full pipelining is allowed.
  - lock0 and lock1 both high: only the current owner's lock matters.
- Address width is exactly clog2(RAM_SIZE). Addresses pass through unchanged, with no wrap or bounds checking.

Decomposition:
- BYTE_LEN, PACKET_BUFFER_SIZE, PACKET_BUFFER_READ_LATENCY and clog2 come from params.vh (included).
- One sub-module, read_tag_pipe:
  - Parameters DELAY_LEN and TAG_WIDTH.
  - A shift register of valid and tag bits with asynchronous clear.
  - Replaces the plain delay used for read_ready.
- The grant logic and the `last`/lock state stay in the top module.

Test Plan (READ_LATENCY=2, RAM preloaded with mem[a] = a[7:0]):
- Single requester: req0 held for 3 cycles with addr 0x10, 0x11, 0x12 -> grant0 in each cycle; ready0 two cycles after each grant with data 0x10, 0x11, 0x12; ready1 stays 0 throughout.
- Contention from reset: req0 and req1 held for 4 cycles (addr0=0x20, addr1=0x30) -> grants alternate 0,1,0,1; returns alternate ready0 0x20, ready1 0x30, and so on, in issue order.
- Burst lock: lock1 and req1 held for 4 cycles while req0 is also high -> grant1 in all 4 cycles. lock1 and req1 drop in cycle 5 -> grant0 in cycle 5, with no idle cycle.
- Reset mid-flight: grant0 at addr 0x40, then reset pulsed the next cycle -> no ready0 or ready1 when the RAM byte returns; ram_read_req is 0 during reset.
- Back-to-back plus idle: req1 for one cycle (addr 0x55), then an idle cycle, then req0 (addr 0x66) -> ready1 0x55 at t+2, ready0 0x66 at t+4; no spurious ready pulse in between.
- Spurious RAM ready: ram_read_ready forced high with no outstanding read -> ready0 and ready1 both stay 0.
